// File: rtl/add8_rr_arbiter.sv
// Round-robin arbiter that shares one combinational 8-bit modular adder among
// nreqs requesters and returns each sum through a one-entry tagged response buffer.
module add8_rr_arbiter #(
  parameter int nreqs = 4,
  localparam int idw = $clog2(nreqs)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [nreqs-1:0]   req_val,
  output logic [nreqs-1:0]   req_rdy,
  input  logic [8*nreqs-1:0] req_in0,
  input  logic [8*nreqs-1:0] req_in1,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [7:0]         resp_out,
  output logic [idw-1:0]     resp_id
);

  localparam int cw = idw + 1;
  localparam logic [cw-1:0]  nreqs_c = cw'(nreqs);
  localparam logic [idw-1:0] last_c  = idw'(nreqs - 1);

  logic [idw-1:0]   ptr_r;
  logic [idw-1:0]   gidx_s;
  logic [idw-1:0]   idx_s;
  logic [idw-1:0]   ptr_next_s;
  logic [cw-1:0]    wrap_s;
  logic [nreqs-1:0] grant_s;
  logic             found_s;
  logic             can_accept_s;
  logic             accept_s;
  logic [7:0]       op0_s [nreqs];
  logic [7:0]       op1_s [nreqs];
  logic [7:0]       in0_s;
  logic [7:0]       in1_s;
  logic [7:0]       sum_s;

  // Unpack operands, scan requesters from ptr upward, and form handshake signals.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    gidx_s  = '0;
    idx_s   = '0;
    wrap_s  = '0;
    in0_s   = 8'h00;
    in1_s   = 8'h00;
    for (int i = 0; i < nreqs; i++) begin
      op0_s[i] = req_in0[8*i +: 8];
      op1_s[i] = req_in1[8*i +: 8];
    end
    for (int k = 0; k < nreqs; k++) begin
      wrap_s = {1'b0, ptr_r} + cw'(k);
      if (wrap_s >= nreqs_c) begin
        wrap_s = wrap_s - nreqs_c;
      end else begin
        wrap_s = wrap_s;
      end
      idx_s = wrap_s[idw-1:0];
      if (!found_s && req_val[idx_s]) begin
        found_s        = 1'b1;
        grant_s[idx_s] = 1'b1;
        gidx_s         = idx_s;
        in0_s          = op0_s[idx_s];
        in1_s          = op1_s[idx_s];
      end else begin
        found_s = found_s;
      end
    end
    // Buffer may be refilled in the same cycle it drains.
    can_accept_s = !resp_val || resp_rdy;
    accept_s     = found_s && can_accept_s;
    req_rdy      = grant_s & {nreqs{can_accept_s & reset_n}};
    sum_s        = in0_s + in1_s;
    ptr_next_s   = (gidx_s == last_c) ? '0 : gidx_s + idw'(1);
  end

  // Response buffer and priority pointer; ptr only advances on an accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_val <= 1'b0;
      resp_out <= 8'h00;
      resp_id  <= '0;
      ptr_r    <= '0;
    end else if (accept_s) begin
      resp_val <= 1'b1;
      resp_out <= sum_s;
      resp_id  <= gidx_s;
      ptr_r    <= ptr_next_s;
    end else if (resp_rdy) begin
      resp_val <= 1'b0;
    end else begin
      resp_val <= resp_val;
    end
  end

endmodule

// File: tb/tb_add8_rr_arbiter.sv
// Randomized scoreboard bench for add8_rr_arbiter: a reference model predicts
// grants and sums, a negedge monitor compares each presented response.
module tb_add8_rr_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_val;
  logic [N-1:0]   req_rdy;
  logic [8*N-1:0] req_in0;
  logic [8*N-1:0] req_in1;
  logic           resp_val;
  logic           resp_rdy;
  logic [7:0]     resp_out;
  logic [1:0]     resp_id;

  logic [7:0] a [N];
  logic [7:0] b [N];

  typedef struct {
    int id;
    int sum;
  } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;
  int mptr = 0;
  int last_out = 0;
  int last_id = 0;
  bit run_mon = 1'b0;

  add8_rr_arbiter #(.nreqs(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_val(req_val), .req_rdy(req_rdy),
    .req_in0(req_in0), .req_in1(req_in1),
    .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_out(resp_out), .resp_id(resp_id)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endfunction

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_in0[8*i +: 8] = a[i];
      req_in1[8*i +: 8] = b[i];
    end
  endtask

  // One clock: predict the grant from the rotating priority, check req_rdy,
  // and queue the expected response when a request is taken.
  task automatic cycle();
    int g;
    bit can_acc;
    int exp_rdy;
    exp_t e;
    pack();
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (mptr + k) % N;
      if (g < 0 && req_val[i]) g = i;
    end
    can_acc = (q.size() == 0) || resp_rdy;
    exp_rdy = (g >= 0 && can_acc) ? (1 << g) : 0;
    chk("req_rdy", int'(req_rdy), exp_rdy);
    if (exp_rdy != 0) begin
      e.id  = g;
      e.sum = (int'(a[g]) + int'(b[g])) % 256;
    end
    @(posedge clk);
    if (exp_rdy != 0) begin
      q.push_back(e);
      mptr = (g + 1) % N;
    end
    #1;
  endtask

  // Monitor: the buffer holds a response exactly when the scoreboard is non-empty.
  always @(negedge clk) begin
    if (run_mon && reset_n) begin
      chk("resp_val", int'(resp_val), (q.size() != 0) ? 1 : 0);
      if (resp_val && q.size() > 0) begin
        chk("resp_out", int'(resp_out), q[0].sum);
        chk("resp_id", int'(resp_id), q[0].id);
        if (resp_rdy) begin
          last_out = q[0].sum;
          last_id  = q[0].id;
          void'(q.pop_front());
        end
      end else if (!resp_val) begin
        chk("idle_out", int'(resp_out), last_out);
        chk("idle_id", int'(resp_id), last_id);
      end
    end
  end

  initial begin
    reset_n  = 1'b0;
    req_val  = 4'b1111;
    resp_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      a[i] = 8'($urandom);
      b[i] = 8'($urandom);
    end
    pack();
    repeat (3) begin
      @(negedge clk);
      chk("rst_resp_val", int'(resp_val), 0);
      chk("rst_resp_out", int'(resp_out), 0);
      chk("rst_resp_id", int'(resp_id), 0);
      chk("rst_req_rdy", int'(req_rdy), 0);
    end
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    run_mon = 1'b1;

    // Fairness: all valid, grants start at requester 0 after reset.
    for (int i = 0; i < N; i++) begin
      a[i] = 8'(i);
      b[i] = 8'h10;
    end
    req_val = 4'b1111;
    repeat (8) cycle();

    // Single request, then 0 and 3 together (3 now has priority).
    a[2] = 8'h12; b[2] = 8'h34;
    req_val = 4'b0100;
    cycle();
    req_val = 4'b1001;
    cycle();

    // Overflow wrap of the sum.
    req_val = 4'b0010;
    a[1] = 8'hFF; b[1] = 8'h01;
    cycle();
    a[1] = 8'h80; b[1] = 8'h80;
    cycle();

    // Backpressure: buffered response stalls requester 1 for three cycles.
    req_val = 4'b0001;
    a[0] = 8'h02; b[0] = 8'h03;
    cycle();
    req_val = 4'b0010;
    a[1] = 8'h21; b[1] = 8'h07;
    resp_rdy = 1'b0;
    repeat (3) cycle();
    resp_rdy = 1'b1;
    cycle();
    req_val = 4'b0000;
    cycle();

    // Random traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      req_val  = 4'($urandom);
      resp_rdy = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        a[i] = 8'($urandom);
        b[i] = 8'($urandom);
      end
      cycle();
    end

    // Asynchronous reset while a response is stalled.
    req_val = 4'b0001;
    a[0] = 8'h11; b[0] = 8'h22;
    resp_rdy = 1'b1;
    cycle();
    resp_rdy = 1'b0;
    cycle();
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_resp_val", int'(resp_val), 0);
    chk("async_rst_req_rdy", int'(req_rdy), 0);
    q.delete();
    last_out = 0;
    last_id  = 0;
    mptr     = 0;
    @(negedge clk);
    chk("async_rst_resp_out", int'(resp_out), 0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    req_val = 4'b1111;
    resp_rdy = 1'b1;
    cycle();
    cycle();

    // Drain everything.
    req_val = 4'b0000;
    repeat (3) cycle();
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add8_rr_arbiter.md
Name: add8_rr_arbiter

Overview:
- Shares a single 8-bit modular adder (out = in0 + in1 mod 256) among NREQ requesters.
- Round-robin arbitration across requesters; val/rdy handshake on every request port; one registered, tagged response port.
- Sits between multiple datapath clients and one adder resource. Result appears one cycle after acceptance.

Parameters:
- nreqs, 4, number of requesters; legal range 2..8.
- idw, $clog2(nreqs), width of the response ID tag; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_val  input  nreqs  per-requester request valid.
- req_rdy  output  nreqs  per-requester ready; at most one bit set.
- req_in0  input  8*nreqs  operand 0; requester i uses bits [8i+7:8i].
- req_in1  input  8*nreqs  operand 1; same packing as req_in0.
- resp_val  output  1  response valid.
- resp_rdy  input  1  consumer ready.
- resp_out  output  8  sum (in0 + in1) mod 256.
- resp_id  output  idw  index of the requester that produced resp_out.

Behaviour:
- Reset (reset_n low, asynchronous):
  - resp_val=0, resp_out=0, resp_id=0, priority pointer ptr=0.
  - req_rdy=0 while reset_n is low.
  - Reset mid-transaction discards any buffered response.
- Output buffer: one entry, made of registers resp_val/resp_out/resp_id.
  - can_accept = !resp_val || resp_rdy. Drain and refill in the same cycle is allowed, so full throughput is one result per cycle.
- Arbitration (combinational):
  - Grant goes to the first i with req_val[i]=1, scanning ptr, ptr+1, ... mod nreqs.
  - No valid requester: grant=0.
  - req_rdy[i] = grant[i] & can_accept.
- Accept: req_val[g] & req_rdy[g] at a rising edge. On the next edge:
  - resp_val=1.
  - resp_out = (req_in0[g] + req_in1[g]) mod 256; carry-out discarded.
  - resp_id = g.
  - ptr = (g+1) mod nreqs.
- Stall (resp_val=1, resp_rdy=0):
  - req_rdy=0.
  - resp_out and resp_id hold stable.
  - ptr holds.
- Drain with no new accept (resp_val & resp_rdy, no request granted):
  - resp_val becomes 0; resp_out and resp_id keep their last values.
- ptr changes only on an accept. Idle cycles and stalls never move it.
- Latency: exactly 1 cycle from accept to resp_val, when the buffer is empty or draining that cycle.
- Requesters may drop req_val before acceptance. Arbitration is re-evaluated every cycle.
- Ordering and fairness: responses are in accept order. With all requesters continuously valid and resp_rdy=1, grants cycle 0,1,2,...,nreqs-1,0. No requester waits more than nreqs-1 accepts.
- Wrap-around: ptr wraps from nreqs-1 to 0. The sum wraps mod 256, e.g. 0xFF+0x01=0x00.
- The adder is purely combinational inside the block. No other arithmetic state is kept.

Test Plan:
- Reset with all inputs active:
  - Stimulus: reset_n=0, req_val=4'b1111.
  - Required: resp_val=0, resp_out=0, resp_id=0, req_rdy=0. After release, requester 0 is granted first.
- Single request:
  - Stimulus: req 2 with in0=8'h12, in1=8'h34, resp_rdy=1.
  - Required: req_rdy=4'b0100 that cycle. Next cycle resp_val=1, resp_out=8'h46, resp_id=2. Then ptr=3, so a simultaneous request from 0 and 3 grants 3.
- Overflow:
  - Stimulus: req 1 with 8'hFF + 8'h01, then 8'h80 + 8'h80.
  - Required: resp_out=8'h00, then 8'h00, with resp_id=1 both times.
- Round-robin fairness:
  - Stimulus: all 4 requesters valid for 8 cycles, requester i sending in0=i, in1=8'h10, resp_rdy=1.
  - Required: resp_id sequence 0,1,2,3,0,1,2,3 with resp_out=8'h10,8'h11,8'h12,8'h13 repeating. resp_val=1 every cycle.
- Backpressure:
  - Stimulus: a response is buffered (id 0, out 8'h05); hold resp_rdy=0 for 3 cycles while req 1 is valid.
  - Required: req_rdy=0, and resp_out/resp_id are stable for those 3 cycles. In the cycle resp_rdy=1, req 1 is accepted, and its result appears the following cycle.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 asynchronously while resp_val=1 and resp_rdy=0.
  - Required: resp_val drops immediately, with no clock edge needed. ptr returns to 0.
